// File: rtl/e_gpu_conf_pkg.sv
// Shared definitions for the e-GPU configuration-port launch sequencer:
// register offsets, FSM state encodings and the write-sequence offset map.
package e_gpu_conf_pkg;

  localparam logic [31:0] OFF_PC     = 32'h0000_000C;
  localparam logic [31:0] OFF_ARG0   = 32'h0000_0010;
  localparam logic [31:0] OFF_ARG1   = 32'h0000_0014;
  localparam logic [31:0] OFF_ARG2   = 32'h0000_0018;
  localparam logic [31:0] OFF_START  = 32'h0000_001C;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0020;

  // Number of writes in one launch: pc, arg0, arg1, arg2, start.
  localparam int NUM_LAUNCH_WR = 5;

  // Launch sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RSP,
    POLL_WAIT,
    RD_REQ,
    RD_RSP,
    DONE
  } launch_state_e;

  // Single-transaction bus master states.
  typedef enum logic [1:0] {
    OBI_IDLE,
    OBI_REQ,
    OBI_RSP
  } obi_state_e;

  // Register offset for write-sequence slot idx (0..4).
  function automatic logic [31:0] wr_offset(input logic [2:0] idx);
    logic [31:0] off;
    case (idx)
      3'd0:    off = OFF_PC;
      3'd1:    off = OFF_ARG0;
      3'd2:    off = OFF_ARG1;
      3'd3:    off = OFF_ARG2;
      default: off = OFF_START;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/obi_single_master.sv
// Single-outstanding OBI master. Takes one command, drives req until gnt,
// then waits for the matching rvalid and hands the response back.
//
// Handshakes:
//   cmd_valid_i/cmd_ready_o: the command is consumed on a cycle where both are
//   high. cmd_ready_o is high exactly on the bus gnt cycle, so the caller must
//   hold cmd_valid_i and its payload stable until then. rsp_valid_o is a
//   one-cycle pulse carrying rsp_rdata_o, with no back-pressure.
//   OBI side: req rises the cycle after the command is seen, stays high with
//   stable addr/we/wdata until gnt, and drops in the cycle after gnt. rvalid
//   is only honoured in the cycles after gnt, so it can never be confused
//   with an earlier transaction's response.
module obi_single_master
  import e_gpu_conf_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output obi_state_e  state_o,
  output logic        conf_req_o,
  output logic        conf_we_o,
  output logic [3:0]  conf_be_o,
  output logic [31:0] conf_addr_o,
  output logic [31:0] conf_wdata_o,
  input  logic        conf_gnt_i,
  input  logic        conf_rvalid_i,
  input  logic [31:0] conf_rdata_i
);

  obi_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // State and bus-output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OBI_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    case (state_q)
      OBI_IDLE: begin
        if (cmd_valid_i) begin
          req_d   = 1'b1;
          we_d    = cmd_we_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          state_d = OBI_REQ;
        end
      end
      OBI_REQ: begin
        if (conf_gnt_i) begin
          cmd_ready_o = 1'b1;
          req_d       = 1'b0;
          state_d     = OBI_RSP;
        end
      end
      OBI_RSP: begin
        if (conf_rvalid_i) begin
          rsp_valid_o = 1'b1;
          rsp_rdata_o = conf_rdata_i;
          state_d     = OBI_IDLE;
        end
      end
      default: state_d = OBI_IDLE;
    endcase
  end

  assign state_o      = state_q;
  assign conf_req_o   = req_q;
  assign conf_we_o    = we_q;
  // Full-word accesses only; byte enables follow req so they idle at zero.
  assign conf_be_o    = {4{req_q}};
  assign conf_addr_o  = addr_q;
  assign conf_wdata_o = wdata_q;

endmodule

// File: rtl/kernel_launch_seq.sv
// On-chip host sequencer for the e-GPU configuration port. A start pulse
// writes pc, arg0..arg2 and the start register, then polls the status
// register until bit 0 is set (or the poll limit is reached).
module kernel_launch_seq
  import e_gpu_conf_pkg::*;
#(
  parameter logic [31:0] CONF_BASE    = 32'h0000_0000,
  parameter int unsigned POLL_GAP     = 16,
  parameter int unsigned POLL_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] arg0_i,
  input  logic [31:0] arg1_i,
  input  logic [31:0] arg2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        conf_req_o,
  output logic        conf_we_o,
  output logic [3:0]  conf_be_o,
  output logic [31:0] conf_addr_o,
  output logic [31:0] conf_wdata_o,
  input  logic        conf_gnt_i,
  input  logic        conf_rvalid_i,
  input  logic [31:0] conf_rdata_i
);

  launch_state_e    state_q, state_d;
  logic [2:0]       wr_idx_q, wr_idx_d;
  logic [31:0]      gap_cnt_q, gap_cnt_d;
  logic [31:0]      poll_cnt_q, poll_cnt_d;
  logic             timeout_q, timeout_d;
  logic [3:0][31:0] shadow_q, shadow_d;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic [31:0]      poll_inc;
  obi_state_e       obi_state;

  // Only the completion flag of the status word matters; the rest, and the
  // bus master's state, are kept visible for debug only.
  logic             unused_dbg;
  assign unused_dbg = ^{rsp_rdata[31:1], obi_state};

  // Sequencer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      gap_cnt_q  <= '0;
      poll_cnt_q <= '0;
      timeout_q  <= 1'b0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      timeout_q  <= timeout_d;
      shadow_q   <= shadow_d;
    end
  end

  // Saturating poll counter increment.
  assign poll_inc = (poll_cnt_q == 32'hFFFF_FFFF) ? poll_cnt_q : poll_cnt_q + 32'd1;

  // Launch sequencing: writes, poll gap, status reads, completion.
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    gap_cnt_d  = gap_cnt_q;
    poll_cnt_d = poll_cnt_q;
    timeout_d  = timeout_q;
    shadow_d   = shadow_q;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          shadow_d   = {arg2_i, arg1_i, arg0_i, pc_i};
          wr_idx_d   = '0;
          poll_cnt_d = '0;
          timeout_d  = 1'b0;
          state_d    = WR_REQ;
        end
      end
      WR_REQ: begin
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = CONF_BASE + wr_offset(wr_idx_q);
        cmd_wdata = (wr_idx_q == 3'(NUM_LAUNCH_WR - 1)) ? 32'h1 : shadow_q[wr_idx_q[1:0]];
        if (cmd_ready) state_d = WR_RSP;
      end
      WR_RSP: begin
        if (rsp_valid) begin
          if (wr_idx_q == 3'(NUM_LAUNCH_WR - 1)) begin
            gap_cnt_d = 32'(POLL_GAP);
            state_d   = POLL_WAIT;
          end else begin
            wr_idx_d = wr_idx_q + 3'd1;
            state_d  = WR_REQ;
          end
        end
      end
      POLL_WAIT: begin
        if (gap_cnt_q == '0) state_d = RD_REQ;
        else                 gap_cnt_d = gap_cnt_q - 32'd1;
      end
      RD_REQ: begin
        cmd_valid = 1'b1;
        cmd_addr  = CONF_BASE + OFF_STATUS;
        if (cmd_ready) state_d = RD_RSP;
      end
      RD_RSP: begin
        if (rsp_valid) begin
          poll_cnt_d = poll_inc;
          if (rsp_rdata[0]) begin
            state_d = DONE;
          end else if ((POLL_TIMEOUT != 0) && (poll_inc == 32'(POLL_TIMEOUT))) begin
            timeout_d = 1'b1;
            state_d   = DONE;
          end else begin
            gap_cnt_d = 32'(POLL_GAP);
            state_d   = POLL_WAIT;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q != IDLE) && (state_q != DONE);
  assign done_o    = (state_q == DONE);
  assign timeout_o = timeout_q;

  obi_single_master u_obi (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_we_i      (cmd_we),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .state_o       (obi_state),
    .conf_req_o    (conf_req_o),
    .conf_we_o     (conf_we_o),
    .conf_be_o     (conf_be_o),
    .conf_addr_o   (conf_addr_o),
    .conf_wdata_o  (conf_wdata_o),
    .conf_gnt_i    (conf_gnt_i),
    .conf_rvalid_i (conf_rvalid_i),
    .conf_rdata_i  (conf_rdata_i)
  );

endmodule
